// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares a single-port data memory between the core
// load/store path (port 0) and the debug/loader path (port 1), one
// transaction at a time, with a fixed memory read latency.
module dmem_port_arbiter #(
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned DMEM_WORDS  = 1024,
    parameter int unsigned FIXED_PRIO  = 0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          p0_valid,
    output logic                          p0_ready,
    input  logic                          p0_we,
    input  logic [31:0]                   p0_addr,
    input  logic [31:0]                   p0_wdata,
    input  logic [3:0]                    p0_wstrb,
    output logic                          p0_rvalid,
    output logic [31:0]                   p0_rdata,
    output logic                          p0_err,
    input  logic                          p1_valid,
    output logic                          p1_ready,
    input  logic                          p1_we,
    input  logic [31:0]                   p1_addr,
    input  logic [31:0]                   p1_wdata,
    input  logic [3:0]                    p1_wstrb,
    output logic                          p1_rvalid,
    output logic [31:0]                   p1_rdata,
    output logic                          p1_err,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [$clog2(DMEM_WORDS)-1:0] mem_addr,
    output logic [31:0]                   mem_wdata,
    output logic [3:0]                    mem_wstrb,
    input  logic [31:0]                   mem_rdata,
    output logic                          busy,
    output logic                          grant_id
);
    localparam int unsigned AW = $clog2(DMEM_WORDS);
    localparam int unsigned CW = 2;
    localparam logic [32:0] ADDR_LIMIT = 33'(DMEM_WORDS) << 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          gnt_c, accept_c;
    logic          last_grant_q, owner_q, req_we_q, req_err_q;
    logic [CW-1:0] cnt_q;
    logic          sel_we_c, sel_err_c;
    logic [31:0]   sel_addr_c, sel_wdata_c, resp_data_c;
    logic [3:0]    sel_wstrb_c;

    // Arbitration, handshake and range check of the winning request
    always_comb begin
        gnt_c = 1'b0;
        if (p0_valid && p1_valid) begin
            gnt_c = (FIXED_PRIO != 0) ? 1'b1 : ~last_grant_q;
        end else begin
            gnt_c = p1_valid;
        end
        accept_c    = reset_n && (state_q == S_IDLE) && (p0_valid || p1_valid);
        p0_ready    = accept_c && !gnt_c;
        p1_ready    = accept_c && gnt_c;
        sel_we_c    = gnt_c ? p1_we    : p0_we;
        sel_addr_c  = gnt_c ? p1_addr  : p0_addr;
        sel_wdata_c = gnt_c ? p1_wdata : p0_wdata;
        sel_wstrb_c = gnt_c ? p1_wstrb : p0_wstrb;
        sel_err_c   = ({1'b0, sel_addr_c} >= ADDR_LIMIT) ||
                      ((sel_addr_c[1:0] != 2'b00) && (sel_wstrb_c == 4'hF));
        resp_data_c = (state_q == S_WAIT && !req_we_q && !req_err_q) ? mem_rdata : 32'h0;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept_c) state_d = S_ISSUE;
            S_ISSUE: state_d = req_err_q ? S_RESP : S_WAIT;
            S_WAIT:  if (cnt_q == '0) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Request latch, memory strobes, latency counter and response registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            req_we_q     <= 1'b0;
            req_err_q    <= 1'b0;
            cnt_q        <= '0;
            grant_id     <= 1'b0;
            busy         <= 1'b0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= 32'h0;
            mem_wstrb    <= 4'h0;
            p0_rvalid    <= 1'b0;
            p0_rdata     <= 32'h0;
            p0_err       <= 1'b0;
            p1_rvalid    <= 1'b0;
            p1_rdata     <= 32'h0;
            p1_err       <= 1'b0;
        end else begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            busy      <= (state_d != S_IDLE);
            if (accept_c) begin
                owner_q      <= gnt_c;
                last_grant_q <= gnt_c;
                grant_id     <= gnt_c;
                req_we_q     <= sel_we_c;
                req_err_q    <= sel_err_c;
                mem_en       <= !sel_err_c;
                mem_we       <= sel_we_c && !sel_err_c;
                mem_addr     <= sel_addr_c[AW+1:2];
                mem_wdata    <= sel_wdata_c;
                mem_wstrb    <= sel_wstrb_c;
            end
            if (state_q == S_ISSUE) begin
                cnt_q <= CW'(MEM_LATENCY - 1);
            end else if (state_q == S_WAIT && cnt_q != '0) begin
                cnt_q <= cnt_q - CW'(1);
            end
            if (state_d == S_RESP) begin
                if (owner_q) begin
                    p1_rvalid <= 1'b1;
                    p1_rdata  <= resp_data_c;
                    p1_err    <= req_err_q;
                end else begin
                    p0_rvalid <= 1'b1;
                    p0_rdata  <= resp_data_c;
                    p0_err    <= req_err_q;
                end
            end
        end
    end
endmodule
